// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked MEM stage: funct3 encodings, load FSM states,
// byte-enable generation, store lane replication and load extension.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            MEM_H, MEM_HU: return off[0];
            MEM_W:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            MEM_B, MEM_BU: return 4'b0001 << off;
            MEM_H, MEM_HU: return 4'b0011 << off;
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] d);
        case (funct3)
            MEM_B, MEM_BU: return {4{d[7:0]}};
            MEM_H, MEM_HU: return {2{d[15:0]}};
            default:       return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            MEM_B:   return {{24{b[7]}}, b};
            MEM_H:   return {{16{h[15]}}, h};
            MEM_BU:  return {24'd0, b};
            MEM_HU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank_be.sv
// One data-memory bank: byte-enabled synchronous write, read data and rvalid delivered
// READ_LATENCY clocks after re. Array contents are never reset.
module dmem_bank_be #(
    parameter int DEPTH        = 16384,
    parameter int READ_LATENCY = 1,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic          rvalid,
    output logic [31:0]   rdata
);

    logic [31:0]             mem       [DEPTH];
    logic [31:0]             pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) pipe_data[0] <= mem[addr];
        for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= re;
            for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    assign rvalid = pipe_vld[READ_LATENCY-1];
    assign rdata  = pipe_data[READ_LATENCY-1];

endmodule

// File: rtl/mem_stage_banked.sv
// RV32 MEM stage over NUM_BANKS word-interleaved banks with multi-cycle loads.
//   state | meaning
//   IDLE  | no load outstanding; an aligned load is issued and stalls this cycle
//   WAIT  | load in flight; count down and wait for the bank's rvalid
//   DONE  | read_data_MEMWB holds the extended load data, stall released
module mem_stage_banked
    import mem_pkg::*;
#(
    parameter int NUM_BANKS    = 4,
    parameter int BANK_DEPTH   = 16384,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic        m_JAL,
    input  logic        m_LUI,
    input  logic [2:0]  m_funct3,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    input  logic [31:0] wb_data,
    input  logic        wb_forward,
    input  logic [31:0] m_imm,
    input  logic [31:0] m_pc_inc,
    output logic        stall_mem,
    output logic        mem_misaligned,
    output logic [31:0] read_data_MEMWB,
    output logic [31:0] reg_data_MEMWB
);

    localparam int         BS       = $clog2(NUM_BANKS);
    localparam int         SELW     = (BS > 0) ? BS : 1;
    localparam int         RW       = $clog2(BANK_DEPTH);
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    ld_state_e       state;
    logic [1:0]      cnt;
    logic [SELW-1:0] cap_bank;
    logic [1:0]      cap_off;
    logic [2:0]      cap_funct3;

    logic [SELW-1:0]      bank_sel;
    logic [RW-1:0]        row;
    logic                 misaligned;
    logic                 load_go;
    logic                 store_go;
    logic [3:0]           be;
    logic [31:0]          store_data;
    logic [NUM_BANKS-1:0] bank_rvalid;
    logic [31:0]          bank_rdata [NUM_BANKS];
    logic                 sel_rvalid;
    logic [31:0]          sel_rdata;
    logic                 unused_addr_hi;

    // Bits above the row field are ignored, so the memory aliases every 4*NUM_BANKS*BANK_DEPTH bytes.
    assign bank_sel       = (BS > 0) ? m_alu_out[2 +: SELW] : '0;
    assign row            = m_alu_out[2+BS +: RW];
    assign unused_addr_hi = ^m_alu_out[31:2+BS+RW];

    assign misaligned = is_misaligned(m_funct3, m_alu_out[1:0]);
    assign load_go    = m_MemRead && !misaligned && (state == ST_IDLE);
    assign store_go   = m_MemWrite && !m_MemRead && !misaligned;
    assign be         = byte_en(m_funct3, m_alu_out[1:0]);
    assign store_data = store_lanes(m_funct3, wb_forward ? wb_data : m_mem_data);

    // Gated by rst_n so an aborted load releases the pipeline in the same cycle reset asserts.
    assign stall_mem      = rst_n && (load_go || (state == ST_WAIT));
    assign mem_misaligned = rst_n && (m_MemRead || m_MemWrite) && misaligned;
    assign reg_data_MEMWB = m_JAL ? m_pc_inc : (m_LUI ? m_imm : m_alu_out);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dmem_bank_be #(
            .DEPTH       (BANK_DEPTH),
            .READ_LATENCY(READ_LATENCY)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .re    (load_go && (bank_sel == SELW'(b))),
            .we    (store_go && (bank_sel == SELW'(b))),
            .addr  (row),
            .be    (be),
            .wdata (store_data),
            .rvalid(bank_rvalid[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (cap_bank == SELW'(b)) begin
                sel_rvalid = bank_rvalid[b];
                sel_rdata  = bank_rdata[b];
            end
        end
    end

    // Load data is written on the WAIT->DONE edge so it is stable throughout DONE.
    // A misaligned load clears read_data_MEMWB at the end of its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            cap_bank        <= '0;
            cap_off         <= '0;
            cap_funct3      <= '0;
            read_data_MEMWB <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_go) begin
                        state      <= ST_WAIT;
                        cnt        <= CNT_INIT;
                        cap_bank   <= bank_sel;
                        cap_off    <= m_alu_out[1:0];
                        cap_funct3 <= m_funct3;
                    end else if (m_MemRead && misaligned) begin
                        read_data_MEMWB <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else if (sel_rvalid) begin
                        state           <= ST_DONE;
                        read_data_MEMWB <= load_extend(cap_funct3, cap_off, sel_rdata);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_banked.sv
// Scoreboard bench: four DUTs with READ_LATENCY 1..4 run the same directed program in turn;
// a negedge monitor retires each access and compares stall length, misalignment, reg and load data.
module tb_mem_stage_banked;
    import mem_pkg::*;

    localparam int          NUM_BANKS  = 4;
    localparam int          BANK_DEPTH = 16384;
    localparam int          NDUT       = 4;
    localparam logic [31:0] ALIAS_ADDR = 32'(4 * NUM_BANKS * BANK_DEPTH);
    localparam logic [31:0] IMM        = 32'h000AB000;
    localparam logic [31:0] PC_INC     = 32'h00000104;
    localparam logic [31:0] WB_JUNK    = 32'h5A5A5A5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cur_rd = 0, cur_wr = 0, cur_jal = 0, cur_lui = 0, cur_fwd = 0;
    logic [2:0]  cur_f3 = 3'b000;
    logic [31:0] cur_addr = 0, cur_data = 0, cur_wbd = 0;
    int          active = 0;

    logic        mr_a [NDUT];
    logic        mw_a [NDUT];
    logic        stall_a [NDUT];
    logic        mis_a [NDUT];
    logic [31:0] rd_a [NDUT];
    logic [31:0] reg_a [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign mr_a[g] = cur_rd && (active == g);
        assign mw_a[g] = cur_wr && (active == g);
        mem_stage_banked #(
            .NUM_BANKS   (NUM_BANKS),
            .BANK_DEPTH  (BANK_DEPTH),
            .READ_LATENCY(g + 1)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .m_MemRead      (mr_a[g]),
            .m_MemWrite     (mw_a[g]),
            .m_JAL          (cur_jal),
            .m_LUI          (cur_lui),
            .m_funct3       (cur_f3),
            .m_alu_out      (cur_addr),
            .m_mem_data     (cur_data),
            .wb_data        (cur_wbd),
            .wb_forward     (cur_fwd),
            .m_imm          (IMM),
            .m_pc_inc       (PC_INC),
            .stall_mem      (stall_a[g]),
            .mem_misaligned (mis_a[g]),
            .read_data_MEMWB(rd_a[g]),
            .reg_data_MEMWB (reg_a[g])
        );
    end

    typedef struct {
        string       name;
        logic        is_load;
        logic        late;
        logic        exp_mis;
        int          exp_stall;
        logic [31:0] exp_rd;
        logic [31:0] exp_reg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles per DUT and retires an access when its stall drops.
    int          stall_cnt [NDUT];
    logic        pend_late = 1'b0;
    int          pend_k = 0;
    logic [31:0] pend_rd = '0;
    string       pend_name = "";
    exp_t        me;

    always @(negedge clk) begin
        if (!rst_n) begin
            foreach (stall_cnt[i]) stall_cnt[i] = 0;
            pend_late = 1'b0;
        end else begin
            if (pend_late) begin
                check({pend_name, "_rdata"}, rd_a[pend_k], pend_rd);
                pend_late = 1'b0;
            end
            for (int k = 0; k < NDUT; k++) begin
                if (mr_a[k] || mw_a[k]) begin
                    if (stall_a[k]) begin
                        stall_cnt[k]++;
                    end else if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_retire: dut %0d retired with empty scoreboard", k);
                    end else begin
                        me = sb.pop_front();
                        check({me.name, "_stall"}, 32'(stall_cnt[k]), 32'(me.exp_stall));
                        check({me.name, "_mis"}, 32'(mis_a[k]), 32'(me.exp_mis));
                        check({me.name, "_reg"}, reg_a[k], me.exp_reg);
                        if (me.is_load) begin
                            if (me.late) begin
                                pend_late = 1'b1;
                                pend_k    = k;
                                pend_rd   = me.exp_rd;
                                pend_name = me.name;
                            end else begin
                                check({me.name, "_rdata"}, rd_a[k], me.exp_rd);
                            end
                        end
                        stall_cnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic run_op(input int k, input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input logic mis, input logic fwd = 1'b0,
                          input logic jal = 1'b0, input logic lui = 1'b0);
        exp_t e;
        bit   done;
        e.name      = $sformatf("rl%0d_%s", k + 1, name);
        e.is_load   = rd;
        e.late      = mis;
        e.exp_mis   = mis;
        e.exp_stall = (rd && !mis) ? (k + 1) + 1 : 0;
        e.exp_rd    = exp_rd;
        e.exp_reg   = jal ? PC_INC : (lui ? IMM : addr);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cur_rd   = rd;
        cur_wr   = wr;
        cur_f3   = f3;
        cur_addr = addr;
        cur_fwd  = fwd;
        cur_data = fwd ? 32'h0 : data;
        cur_wbd  = fwd ? data : WB_JUNK;
        cur_jal  = jal;
        cur_lui  = lui;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall_a[k]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: stall_mem still 1 after 20 cycles, required 0", e.name);
            void'(sb.pop_back());
            cur_rd = 1'b0;
            cur_wr = 1'b0;
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        cur_rd  = 1'b0;
        cur_wr  = 1'b0;
        cur_jal = 1'b0;
        cur_lui = 1'b0;
    endtask

    task automatic reset_mid_load(input int k);
        @(posedge clk);
        #1;
        cur_rd   = 1'b1;
        cur_wr   = 1'b0;
        cur_f3   = MEM_W;
        cur_addr = 32'h10;
        cur_fwd  = 1'b0;
        cur_jal  = 1'b0;
        cur_lui  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("rl%0d_rst_wait_stall", k + 1), 32'(stall_a[k]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check($sformatf("rl%0d_rst_stall_drop", k + 1), 32'(stall_a[k]), 32'd0);
        check($sformatf("rl%0d_rst_rdata", k + 1), rd_a[k], 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        cur_rd = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rl%0d_reset_stall", k + 1), 32'(stall_a[k]), 32'd0);
            check($sformatf("rl%0d_reset_mis", k + 1), 32'(mis_a[k]), 32'd0);
            check($sformatf("rl%0d_reset_rdata", k + 1), rd_a[k], 32'h0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < NDUT; k++) begin
            active = k;
            // word store and readback
            run_op(k, "sw_10",   0, 1, MEM_W,  32'h10, 32'hDEADBEEF, 32'h0, 0);
            run_op(k, "lw_10",   1, 0, MEM_W,  32'h10, 32'h0, 32'hDEADBEEF, 0);
            // byte store into lane 3 and sign/zero-extended loads
            run_op(k, "sb_13",   0, 1, MEM_B,  32'h13, 32'h12345680, 32'h0, 0);
            run_op(k, "lb_13",   1, 0, MEM_B,  32'h13, 32'h0, 32'hFFFFFF80, 0);
            run_op(k, "lbu_13",  1, 0, MEM_BU, 32'h13, 32'h0, 32'h00000080, 0);
            run_op(k, "lw_10b",  1, 0, MEM_W,  32'h10, 32'h0, 32'h80ADBEEF, 0);
            run_op(k, "lh_12",   1, 0, MEM_H,  32'h12, 32'h0, 32'hFFFF80AD, 0, 0, 1, 0);
            // halfword store into upper half, misaligned halfword load
            run_op(k, "sw_20",   0, 1, MEM_W,  32'h20, 32'h8765ABCD, 32'h0, 0, 0, 0, 1);
            run_op(k, "sh_22",   0, 1, MEM_H,  32'h22, 32'hFFFF1234, 32'h0, 0);
            run_op(k, "lhu_22",  1, 0, MEM_HU, 32'h22, 32'h0, 32'h00001234, 0);
            run_op(k, "lw_20",   1, 0, MEM_W,  32'h20, 32'h0, 32'h1234ABCD, 0);
            run_op(k, "lh_20",   1, 0, MEM_H,  32'h20, 32'h0, 32'hFFFFABCD, 0);
            run_op(k, "lb_22",   1, 0, MEM_B,  32'h22, 32'h0, 32'h00000034, 0);
            run_op(k, "lbu_21",  1, 0, MEM_BU, 32'h21, 32'h0, 32'h000000AB, 0);
            run_op(k, "lh_21",   1, 0, MEM_H,  32'h21, 32'h0, 32'h00000000, 1);
            // bank walk, aliasing and a dropped misaligned store
            run_op(k, "sw_00",   0, 1, MEM_W,  32'h00, 32'h11111111, 32'h0, 0);
            run_op(k, "sw_04",   0, 1, MEM_W,  32'h04, 32'h22222222, 32'h0, 0);
            run_op(k, "sw_08",   0, 1, MEM_W,  32'h08, 32'h33333333, 32'h0, 0);
            run_op(k, "sw_0c",   0, 1, MEM_W,  32'h0C, 32'h44444444, 32'h0, 0);
            run_op(k, "sw_alias",0, 1, MEM_W,  ALIAS_ADDR, 32'h55555555, 32'h0, 0);
            run_op(k, "sw_06mis",0, 1, MEM_W,  32'h06, 32'hFFFFFFFF, 32'h0, 1);
            run_op(k, "lw_00",   1, 0, MEM_W,  32'h00, 32'h0, 32'h55555555, 0);
            run_op(k, "lw_04",   1, 0, MEM_W,  32'h04, 32'h0, 32'h22222222, 0);
            run_op(k, "lw_08",   1, 0, MEM_W,  32'h08, 32'h0, 32'h33333333, 0);
            run_op(k, "lw_0c",   1, 0, MEM_W,  32'h0C, 32'h0, 32'h44444444, 0);
            run_op(k, "lw_al4",  1, 0, MEM_W,  ALIAS_ADDR + 32'h4, 32'h0, 32'h22222222, 0);
            // reset in WAIT, then a normal load
            go_idle();
            reset_mid_load(k);
            run_op(k, "lw_after_rst", 1, 0, MEM_W, 32'h10, 32'h0, 32'h80ADBEEF, 0);
            // forwarded store data, then load-wins on a read+write collision
            run_op(k, "sw_fwd",  0, 1, MEM_W,  32'h30, 32'hCAFEF00D, 32'h0, 0, 1);
            run_op(k, "lw_30",   1, 0, MEM_W,  32'h30, 32'h0, 32'hCAFEF00D, 0);
            run_op(k, "rdwr_30", 1, 1, MEM_W,  32'h30, 32'h00000000, 32'hCAFEF00D, 0);
            run_op(k, "lw_30b",  1, 0, MEM_W,  32'h30, 32'h0, 32'hCAFEF00D, 0);
            go_idle();
        end

        repeat (4) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
